mac_out_scheduler: RTL and testbench
====================================

Name: mac_out_scheduler

Overview:
- Sequences the output-data FIFO of the MAC array.
- Round-robin arbitrates NumReq MAC result lanes onto the FIFO's single Push/DataIn port.
- Drains the FIFO head through a registered valid/ready output stage by issuing Pop2.
- Sits between the MAC lanes and the output FIFO instance, and between the FIFO and the downstream writer.

Parameters:
- DataWidth, 32, width of one result word.
- BufferSize, 4, FIFO depth; width of the ReadyM occupancy vector.
- NumReq, 4, number of requesting MAC lanes.
- ReqWidth, 2, log2(NumReq); width of the round-robin pointer.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  NumReq  per-lane result-available request.
- req_data  input  NumReq*DataWidth  lane i word at bits [i*DataWidth +: DataWidth].
- ack  output  NumReq  one-hot, registered; pulses the cycle after lane i's word is pushed.
- Full  input  1  FIFO full flag.
- ReadyM  input  BufferSize  FIFO per-slot valid bits; any bit set means the FIFO is non-empty.
- DataOut2  input  DataWidth  FIFO head word (combinational read).
- Push  output  1  FIFO write enable (combinational).
- DataIn  output  DataWidth  FIFO write data (combinational).
- Pop2  output  1  FIFO read-pointer advance (combinational).
- out_valid  output  1  output stage holds a word.
- out_data  output  DataWidth  registered output word.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - rr_ptr=0, ack=0, out_valid=0, out_data=0, state=EMPTY.
  - Push and Pop2 are forced to 0 while in reset.
- Arbitration, combinational each cycle:
  - Search req from lane rr_ptr upward, wrapping modulo NumReq; the first set lane is the winner.
  - Push = (|req) & ~Full; DataIn = winner's word.
  - When Full=1: Push=0, no ack, rr_ptr holds.
  - On a push: ack[winner]<=1 for one cycle; rr_ptr <= winner+1 (wraps NumReq-1 -> 0).
  - A lane must keep req high until its ack.
  - Each ack covers one word; a lane holding req after its ack is treated as a new word.
- Drain FSM, two states:
  - EMPTY (out_valid=0):
    - If |ReadyM: Pop2=1, out_data<=DataOut2, next state FULL.
    - Else: Pop2=0, stay EMPTY.
  - FULL (out_valid=1):
    - If out_ready & |ReadyM: Pop2=1, out_data<=DataOut2, stay FULL. Back-to-back transfers, 1 word/cycle.
    - If out_ready & ~|ReadyM: Pop2=0, next state EMPTY.
    - If ~out_ready: Pop2=0, out_data holds, stay FULL.
- Latency:
  - Lane req to Push: 0 cycles when not Full.
  - Word pushed at cycle N: ReadyM reflects it at N+1; out_valid=1 at N+2.
- Simultaneous Push and Pop2 are permitted; FIFO occupancy is unchanged.
- The FIFO is never overrun, because Push is gated by Full.
- The FIFO is never underrun, because Pop2 requires |ReadyM.
- Reset mid-transfer drops the output word and clears out_valid. The FIFO is reset by the same rst and is therefore consistent.

Optional Feature:
- Macro MAC_OUT_SCHED_STATS_EN. When defined, adds three outputs:
  - push_cnt (16 bits): increments on each Push.
  - stall_cnt (16 bits): increments each cycle with |req & Full.
  - drain_cnt (16 bits): increments on each out_valid & out_ready.
- All three wrap at 16'hFFFF and reset to 0.
- When not defined, these ports and counters are absent and all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 with req=4'b1111 and ReadyM=4'b1111 -> Push=0, Pop2=0, out_valid=0, ack=0. Release -> lane 0 pushed first.
- Round robin: req=4'b1111 held, Full=0 -> push order lanes 0,1,2,3,0; ack sequence 0001,0010,0100,1000,0001 delayed one cycle.
- Full gating: Full=1 with req=4'b0100 for 3 cycles -> Push=0, rr_ptr unchanged, stall_cnt=3 (macro on). Full=0 -> lane 2 pushed; ack[2] next cycle.
- Drain: FIFO holds 0xA1, 0xB2; out_ready=1 -> out_data 0xA1 then 0xB2 on consecutive cycles; two Pop2 pulses; then EMPTY.
- Backpressure: out_valid=1, out_data=0x55, out_ready=0 for 4 cycles with ReadyM non-zero -> Pop2=0, out_data stays 0x55. out_ready=1 -> next word loaded same edge.
- Mid-transfer reset: assert rst=0 while out_valid=1 -> out_valid=0 and out_data=0 immediately (asynchronous); FIFO ReadyM=0 after reset.

Source files
------------

// File: rtl/mac_out_scheduler.sv
// Round-robin MAC lane arbiter feeding the output FIFO, plus a one-word valid/ready drain stage.
// Optional build macro MAC_OUT_SCHED_STATS_EN adds push/stall/drain event counters.
module mac_out_scheduler #(
  parameter int DataWidth  = 32,
  parameter int BufferSize = 4,
  parameter int NumReq     = 4,
  parameter int ReqWidth   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NumReq-1:0]           req,
  input  logic [NumReq*DataWidth-1:0] req_data,
  output logic [NumReq-1:0]           ack,
  input  logic                        Full,
  input  logic [BufferSize-1:0]       ReadyM,
  input  logic [DataWidth-1:0]        DataOut2,
  output logic                        Push,
  output logic [DataWidth-1:0]        DataIn,
  output logic                        Pop2,
  output logic                        out_valid,
  output logic [DataWidth-1:0]        out_data,
  input  logic                        out_ready
`ifdef MAC_OUT_SCHED_STATS_EN
  ,
  output logic [15:0]                 push_cnt,
  output logic [15:0]                 stall_cnt,
  output logic [15:0]                 drain_cnt
`endif
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [ReqWidth-1:0] rr_ptr;
  logic [ReqWidth-1:0] winner;
  logic [ReqWidth-1:0] idx;
  logic                found;
  logic                any_ready;

  // Search starts at rr_ptr so the lane served last drops to lowest priority
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NumReq; i++) begin
      idx = ReqWidth'((int'(rr_ptr) + i) % NumReq);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign Push      = rst & found & ~Full;
  assign DataIn    = req_data[int'(winner)*DataWidth +: DataWidth];
  assign any_ready = |ReadyM;
  assign out_valid = (state == S_FULL);

  always_comb begin
    next_state = state;
    Pop2       = 1'b0;
    case (state)
      S_EMPTY: begin
        if (any_ready) begin
          Pop2       = 1'b1;
          next_state = S_FULL;
        end
      end
      S_FULL: begin
        if (out_ready) begin
          if (any_ready) Pop2 = 1'b1;
          else           next_state = S_EMPTY;
        end
      end
      default: next_state = S_EMPTY;
    endcase
    if (!rst) Pop2 = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_EMPTY;
      out_data <= '0;
      ack      <= '0;
      rr_ptr   <= '0;
    end else begin
      state <= next_state;
      if (Pop2) out_data <= DataOut2;
      ack <= Push ? (NumReq'(1) << winner) : '0;
      if (Push) begin
        rr_ptr <= (winner == ReqWidth'(NumReq-1)) ? '0 : winner + 1'b1;
      end
    end
  end

`ifdef MAC_OUT_SCHED_STATS_EN
  // Free-running 16-bit counters that wrap naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      push_cnt  <= '0;
      stall_cnt <= '0;
      drain_cnt <= '0;
    end else begin
      if (Push)               push_cnt  <= push_cnt + 16'd1;
      if ((|req) && Full)     stall_cnt <= stall_cnt + 16'd1;
      if (out_valid && out_ready) drain_cnt <= drain_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_out_scheduler.sv
// Randomized self-checking bench for mac_out_scheduler with a queue-based FIFO and lane model.
module tb_mac_out_scheduler;
  localparam int DW = 32;
  localparam int BS = 4;
  localparam int NR = 4;
  localparam int RW = 2;

  typedef logic [DW-1:0] word_q_t[$];

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     ack;
  logic              Full;
  logic [BS-1:0]     ReadyM;
  logic [DW-1:0]     DataOut2;
  logic              Push;
  logic [DW-1:0]     DataIn;
  logic              Pop2;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic              out_ready;
`ifdef MAC_OUT_SCHED_STATS_EN
  logic [15:0]       push_cnt;
  logic [15:0]       stall_cnt;
  logic [15:0]       drain_cnt;
`endif

  mac_out_scheduler #(
    .DataWidth(DW), .BufferSize(BS), .NumReq(NR), .ReqWidth(RW)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .Full(Full), .ReadyM(ReadyM), .DataOut2(DataOut2), .Push(Push),
    .DataIn(DataIn), .Pop2(Pop2), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready)
`ifdef MAC_OUT_SCHED_STATS_EN
    , .push_cnt(push_cnt), .stall_cnt(stall_cnt), .drain_cnt(drain_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: per-lane pending words, FIFO contents, output holding register
  word_q_t       lane_q[NR];
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] push_log[$];
  int            m_rr;
  logic [NR-1:0] m_ack;
  bit            m_hold_valid;
  logic [DW-1:0] m_hold_data;
  bit            force_full;
  bit            force_ready;
  int            ready_mode;
  int            hs_count;
  int            checks;
  int            errors;

  task automatic drive_inputs();
    for (int i = 0; i < NR; i++) begin
      req[i] = (lane_q[i].size() > 0);
      req_data[i*DW +: DW] = (lane_q[i].size() > 0) ? lane_q[i][0] : '0;
    end
    Full = (fifo_q.size() >= BS) || force_full;
    for (int i = 0; i < BS; i++) ReadyM[i] = force_ready || (i < fifo_q.size());
    DataOut2 = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic clear_model();
    for (int i = 0; i < NR; i++) lane_q[i].delete();
    fifo_q.delete();
    push_log.delete();
    m_rr = 0;
    m_ack = '0;
    m_hold_valid = 0;
    m_hold_data = '0;
    force_full = 0;
    force_ready = 0;
    hs_count = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_model();
    drive_inputs();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // One clock of stimulus, comparison against the model, then model update
  task automatic run_cycle(input string tag);
    int            w;
    bit            exp_push;
    bit            exp_pop;
    bit            full_now;
    bit            rdy_now;
    logic [DW-1:0] exp_word;
    drive_inputs();
    #2;
    full_now = Full;
    rdy_now  = out_ready;
    w = -1;
    for (int k = 0; k < NR; k++) begin
      int l;
      l = (m_rr + k) % NR;
      if (w < 0 && lane_q[l].size() > 0) w = l;
    end
    exp_push = rst && (w >= 0) && !full_now;
    exp_pop  = rst && (fifo_q.size() > 0) && (!m_hold_valid || rdy_now);
    exp_word = exp_push ? lane_q[w][0] : '0;

    checks++;
    if (Push !== exp_push) begin
      errors++;
      $display("[TB] FAIL %s Push: got %0b expected %0b at %0t", tag, Push, exp_push, $time);
    end
    if (exp_push) begin
      checks++;
      if (DataIn !== exp_word) begin
        errors++;
        $display("[TB] FAIL %s DataIn: got %h expected %h at %0t", tag, DataIn, exp_word, $time);
      end
    end
    checks++;
    if (Pop2 !== exp_pop) begin
      errors++;
      $display("[TB] FAIL %s Pop2: got %0b expected %0b at %0t", tag, Pop2, exp_pop, $time);
    end
    checks++;
    if (out_valid !== m_hold_valid) begin
      errors++;
      $display("[TB] FAIL %s out_valid: got %0b expected %0b at %0t", tag, out_valid, m_hold_valid, $time);
    end
    checks++;
    if (out_data !== m_hold_data) begin
      errors++;
      $display("[TB] FAIL %s out_data: got %h expected %h at %0t", tag, out_data, m_hold_data, $time);
    end
    checks++;
    if (ack !== m_ack) begin
      errors++;
      $display("[TB] FAIL %s ack: got %b expected %b at %0t", tag, ack, m_ack, $time);
    end
    if (out_valid === 1'b1 && rdy_now) hs_count++;

    @(posedge clk);
    #1;
    if (rst) begin
      if (exp_pop) begin
        m_hold_data  = fifo_q.pop_front();
        m_hold_valid = 1;
      end else if (m_hold_valid && rdy_now) begin
        m_hold_valid = 0;
      end
      m_ack = '0;
      if (exp_push) begin
        fifo_q.push_back(exp_word);
        void'(lane_q[w].pop_front());
        push_log.push_back(exp_word);
        m_ack[w] = 1'b1;
        m_rr = (w + 1) % NR;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_model();
    ready_mode = 0;
    for (int i = 0; i < NR; i++) lane_q[i].push_back(32'h1000_0000 + i);
    force_ready = 1;
    run_cycle("reset_hold");
    run_cycle("reset_hold");
    force_ready = 0;
    rst = 1'b1;
    run_cycle("reset_release");
    checks++;
    if (push_log.size() != 1 || push_log[0] !== 32'h1000_0000) begin
      errors++;
      $display("[TB] FAIL reset_first_lane: got %0d pushes first %h expected lane0 word 10000000",
               push_log.size(), (push_log.size() > 0) ? push_log[0] : 32'h0);
    end
    for (int i = 0; i < 8; i++) run_cycle("reset_drain");
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    ready_mode = 0;
    for (int i = 0; i < NR; i++)
      for (int s = 0; s < 3; s++) lane_q[i].push_back(32'hC0DE_0000 | (i << 8) | s);
    for (int c = 0; c < 5; c++) run_cycle("rr");
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (push_log.size() <= k || push_log[k][15:8] !== 8'(exp_order[k])) begin
        errors++;
        $display("[TB] FAIL rr_order[%0d]: got lane %0d expected lane %0d", k,
                 (push_log.size() > k) ? int'(push_log[k][15:8]) : -1, exp_order[k]);
      end
    end
    for (int c = 0; c < 16; c++) run_cycle("rr_drain");
  endtask

  task automatic test_full_gating();
    do_reset();
    ready_mode = 0;
    lane_q[2].push_back(32'h2222_0002);
    force_full = 1;
    for (int c = 0; c < 3; c++) run_cycle("full_gate");
`ifdef MAC_OUT_SCHED_STATS_EN
    checks++;
    if (stall_cnt !== 16'd3) begin
      errors++;
      $display("[TB] FAIL stall_cnt: got %0d expected 3", stall_cnt);
    end
`endif
    force_full = 0;
    run_cycle("full_release");
    run_cycle("full_ack");
    checks++;
    if (push_log.size() != 1 || push_log[0] !== 32'h2222_0002) begin
      errors++;
      $display("[TB] FAIL full_release_push: got %0d pushes expected one lane2 push", push_log.size());
    end
    for (int c = 0; c < 4; c++) run_cycle("full_drain");
  endtask

  task automatic test_drain();
    do_reset();
    ready_mode = 0;
    fifo_q.push_back(32'h0000_00A1);
    fifo_q.push_back(32'h0000_00B2);
    for (int c = 0; c < 4; c++) run_cycle("drain");
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain_empty: got out_valid %0b expected 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready_mode = 1;
    fifo_q.push_back(32'h0000_0055);
    fifo_q.push_back(32'h0000_0066);
    fifo_q.push_back(32'h0000_0077);
    for (int c = 0; c < 5; c++) run_cycle("backpressure");
    ready_mode = 0;
    run_cycle("bp_release");
    checks++;
    if (out_data !== 32'h0000_0066) begin
      errors++;
      $display("[TB] FAIL bp_next_word: got %h expected 00000066", out_data);
    end
    for (int c = 0; c < 4; c++) run_cycle("bp_drain");
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready_mode = 1;
    fifo_q.push_back(32'h1234_5678);
    fifo_q.push_back(32'h9ABC_DEF0);
    run_cycle("mid_fill");
    run_cycle("mid_fill");
    lane_q[1].push_back(32'h0BAD_0001);
    drive_inputs();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset_out: got valid %0b data %h expected 0/0", out_valid, out_data);
    end
    checks++;
    if (Push !== 1'b0 || Pop2 !== 1'b0 || ack !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset_ctrl: got Push %0b Pop2 %0b ack %b expected 0", Push, Pop2, ack);
    end
    do_reset();
    ready_mode = 0;
    lane_q[1].push_back(32'h0BAD_0001);
    for (int c = 0; c < 5; c++) run_cycle("mid_after");
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++)
        if (lane_q[i].size() < 2 && $urandom_range(0, 9) < 4) lane_q[i].push_back($urandom);
      ready_mode = ($urandom_range(0, 3) == 0) ? 1 : 2;
      force_full = ($urandom_range(0, 9) == 0);
      run_cycle("random");
    end
    force_full = 0;
    ready_mode = 0;
    for (int c = 0; c < 40; c++) run_cycle("random_drain");
    checks++;
    if (hs_count != push_log.size()) begin
      errors++;
      $display("[TB] FAIL random_conservation: got %0d handshakes expected %0d", hs_count, push_log.size());
    end
`ifdef MAC_OUT_SCHED_STATS_EN
    checks++;
    if (push_cnt !== 16'(push_log.size()) || drain_cnt !== 16'(hs_count)) begin
      errors++;
      $display("[TB] FAIL stats_counts: got push %0d drain %0d expected %0d/%0d",
               push_cnt, drain_cnt, push_log.size(), hs_count);
    end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ready_mode = 0;
    rst = 1'b0;
    req = '0;
    req_data = '0;
    Full = 1'b0;
    ReadyM = '0;
    DataOut2 = '0;
    out_ready = 1'b0;
    #3;
    test_reset();
    test_round_robin();
    test_full_gating();
    test_drain();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
